// File: rtl/test_sink_rr_arbiter_if.sv
// Handshake bundle between the val/rdy sources, the round-robin arbiter and
// the shared test sink. Requester i owns in_msg[i*p_msg_nbits +: p_msg_nbits].
// The output message carries {source id, payload}, with the id in the MSBs.
// Valid/ready rule on both sides: a transfer happens on a rising clock edge
// where val && rdy. A source holds its val and message until that edge.
// rdy may depend on val on the request side; out_val/out_msg never depend
// combinationally on the request side.
interface test_sink_rr_arbiter_if #(
  parameter int p_num_reqs  = 4,
  parameter int p_msg_nbits = 32,
  parameter int p_id_nbits  = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1
);
  logic [p_num_reqs-1:0]             in_val;
  logic [p_num_reqs-1:0]             in_rdy;
  logic [p_num_reqs*p_msg_nbits-1:0] in_msg;
  logic                              out_val;
  logic                              out_rdy;
  logic [p_id_nbits+p_msg_nbits-1:0] out_msg;

  // Harness side: drives the requests and the sink ready.
  modport master (
    output in_val, in_msg, out_rdy,
    input  in_rdy, out_val, out_msg
  );

  // Arbiter side.
  modport slave (
    input  in_val, in_msg, out_rdy,
    output in_rdy, out_val, out_msg
  );
endinterface

// File: rtl/test_sink_rr_arbiter.sv
// Round-robin arbiter sharing one test sink among several val/rdy sources.
// One valid requester is picked per cycle, starting at grant_ptr. Its message
// is tagged with the source index and captured in a single-entry output
// buffer. Completed output transfers are counted, and the count saturates.
module test_sink_rr_arbiter #(
  parameter int p_num_reqs  = 4,
  parameter int p_msg_nbits = 32,
  parameter int p_id_nbits  = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  test_sink_rr_arbiter_if.slave bus,
  output logic [p_id_nbits-1:0] grant_ptr,
  output logic [31:0]           xfer_count
);

  logic [p_msg_nbits-1:0]            msg_arr [p_num_reqs];
  logic                              out_val_q;
  logic [p_id_nbits+p_msg_nbits-1:0] out_msg_q;
  logic                              can_accept;
  logic                              fire;
  logic                              found;
  logic                              accept;
  logic [p_id_nbits-1:0]             winner;
  logic [p_id_nbits:0]               idx_ext;
  logic [p_id_nbits-1:0]             idx;

  // View the flat request bus as one payload per requester.
  for (genvar g = 0; g < p_num_reqs; g++) begin : g_unpack
    assign msg_arr[g] = bus.in_msg[g*p_msg_nbits +: p_msg_nbits];
  end

  // A full buffer that drains this cycle can be refilled in the same cycle.
  assign can_accept  = !out_val_q || bus.out_rdy;
  assign fire        = out_val_q && bus.out_rdy;
  // Nothing is accepted while reset is held. Reset is active-low.
  assign accept      = found && can_accept && reset;
  assign bus.out_val = out_val_q;
  assign bus.out_msg = out_msg_q;

  // Search the requesters from grant_ptr upward. The index wraps explicitly
  // at p_num_reqs, so counts that are not a power of two work correctly.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    idx_ext = '0;
    idx     = '0;
    for (int k = 0; k < p_num_reqs; k++) begin
      idx_ext = {1'b0, grant_ptr} + (p_id_nbits+1)'(k);
      if (idx_ext >= (p_id_nbits+1)'(p_num_reqs)) begin
        idx_ext = idx_ext - (p_id_nbits+1)'(p_num_reqs);
      end
      idx = idx_ext[p_id_nbits-1:0];
      if (!found && bus.in_val[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Only the winner sees ready, and only when the buffer can take a message.
  always_comb begin
    bus.in_rdy = '0;
    if (accept) begin
      bus.in_rdy[winner] = 1'b1;
    end
  end

  // Output buffer and priority pointer. On an accept, the buffer loads the
  // winner and the pointer moves past it. If the buffer drains with no new
  // accept, it empties; the message bits are held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_val_q <= 1'b0;
      out_msg_q <= '0;
      grant_ptr <= '0;
    end else if (accept) begin
      out_val_q <= 1'b1;
      out_msg_q <= {winner, msg_arr[winner]};
      grant_ptr <= (winner == p_id_nbits'(p_num_reqs - 1)) ? '0 : winner + 1'b1;
    end else if (fire) begin
      out_val_q <= 1'b0;
    end
  end

  // Count completed output transfers, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xfer_count <= '0;
    end else if (fire && (xfer_count != 32'hFFFF_FFFF)) begin
      xfer_count <= xfer_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_test_sink_rr_arbiter.sv
// Directed bench for test_sink_rr_arbiter. Instance A has 4 requesters and is
// checked against a cycle model. Instance B has 3 requesters and feeds a
// random-delay sink.
module tb_test_sink_rr_arbiter;
  localparam int NA = 4;
  localparam int WA = 32;
  localparam int IA = 2;
  localparam int NB = 3;
  localparam int WB = 16;
  localparam int IB = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [IA-1:0] ptr_a;
  logic [31:0]   cnt_a;
  logic [IB-1:0] ptr_b;
  logic [31:0]   cnt_b;

  always #5 clk = ~clk;

  test_sink_rr_arbiter_if #(.p_num_reqs(NA), .p_msg_nbits(WA)) bus_a ();
  test_sink_rr_arbiter_if #(.p_num_reqs(NB), .p_msg_nbits(WB)) bus_b ();

  test_sink_rr_arbiter #(.p_num_reqs(NA), .p_msg_nbits(WA)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .grant_ptr(ptr_a), .xfer_count(cnt_a)
  );
  test_sink_rr_arbiter #(.p_num_reqs(NB), .p_msg_nbits(WB)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .grant_ptr(ptr_b), .xfer_count(cnt_b)
  );

  logic [WA-1:0] pay [NA];
  logic [WB-1:0] payb [NB];
  for (genvar g = 0; g < NA; g++) begin : g_pack_a
    assign bus_a.in_msg[g*WA +: WA] = pay[g];
  end
  for (genvar g = 0; g < NB; g++) begin : g_pack_b
    assign bus_b.in_msg[g*WB +: WB] = payb[g];
  end

  int checks   = 0;
  int failures = 0;

  // Scoreboards: expected messages in order of acceptance.
  logic [IA+WA-1:0] exp_q[$];
  logic [IB+WB-1:0] exp_qb[$];

  // Reference state for instance A.
  logic          m_val;
  logic [IA+WA-1:0] m_msg;
  logic [IA-1:0] m_ptr;
  logic [31:0]   m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_val = 1'b0;
    m_msg = '0;
    m_ptr = '0;
    m_cnt = '0;
    exp_q.delete();
  endtask

  // One cycle of instance A. The caller has driven inputs at the negedge.
  // Checks ready and any output fire before the edge, and the registered
  // state after it. Returns at the next negedge.
  task automatic step_a();
    logic          can;
    logic          found;
    logic          acc;
    logic          fire;
    int            w;
    int            idx;
    logic [NA-1:0] exp_rdy;
    #1;
    can   = !m_val || bus_a.out_rdy;
    found = 1'b0;
    w     = 0;
    for (int k = 0; k < NA; k++) begin
      idx = (int'(m_ptr) + k) % NA;
      if (!found && bus_a.in_val[idx]) begin
        found = 1'b1;
        w     = idx;
      end
    end
    acc     = found && can;
    exp_rdy = '0;
    if (acc) exp_rdy[w] = 1'b1;
    check("in_rdy", 64'(bus_a.in_rdy), 64'(exp_rdy));
    fire = m_val && bus_a.out_rdy;
    if (fire) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("sb_out_msg", 64'(bus_a.out_msg), 64'(exp_q.pop_front()));
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
    if (acc) begin
      m_msg = {w[IA-1:0], pay[w]};
      exp_q.push_back(m_msg);
      m_val = 1'b1;
      m_ptr = (w == NA - 1) ? '0 : IA'(w + 1);
    end else if (fire) begin
      m_val = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    if (acc) pay[w] = pay[w] + 32'h100;
    check("out_val", 64'(bus_a.out_val), 64'(m_val));
    check("out_msg", 64'(bus_a.out_msg), 64'(m_msg));
    check("grant_ptr", 64'(ptr_a), 64'(m_ptr));
    check("xfer_count", 64'(cnt_a), 64'(m_cnt));
  endtask

  int            recv;
  int            wait_b;
  int            bp;
  logic [NB-1:0] acc_b;
  logic [NB-1:0] onehot_b;
  logic [IB-1:0] mb_ptr;

  initial begin
    // Clock/reset: hold reset with requests pending. Ready must stay low.
    reset = 1'b0;
    for (int i = 0; i < NA; i++) pay[i] = WA'(32'hA0 + i);
    for (int i = 0; i < NB; i++) payb[i] = WB'(i * 16'h1000);
    bus_a.in_val  = '1;
    bus_a.out_rdy = 1'b1;
    bus_b.in_val  = '0;
    bus_b.out_rdy = 1'b0;
    model_reset();
    #1;
    check("rst_out_val", 64'(bus_a.out_val), 64'd0);
    check("rst_out_msg", 64'(bus_a.out_msg), 64'd0);
    check("rst_grant_ptr", 64'(ptr_a), 64'd0);
    check("rst_xfer_count", 64'(cnt_a), 64'd0);
    @(negedge clk);
    check("rst_in_rdy", 64'(bus_a.in_rdy), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // All requesters valid, sink always ready: ids rotate 0,1,2,3,...
    for (int s = 0; s < 9; s++) step_a();
    check("fair_xfer8", 64'(cnt_a), 64'd8);
    bus_a.in_val = '0;
    step_a();

    // Only requester 2: back-to-back outputs, pointer parks at 3.
    bus_a.in_val = 4'b0100;
    for (int s = 0; s < 5; s++) begin
      step_a();
      check("only2_ptr", 64'(ptr_a), 64'd3);
    end
    bus_a.in_val = '0;
    step_a();

    // Backpressure with requesters 1 and 3: the buffer fills with 3, then stalls.
    bus_a.in_val  = 4'b1010;
    bus_a.out_rdy = 1'b0;
    for (int s = 0; s < 7; s++) step_a();
    check("bp_held_id", 64'(bus_a.out_msg[IA+WA-1 -: IA]), 64'd3);
    bus_a.out_rdy = 1'b1;
    step_a();
    check("bp_refill_id", 64'(bus_a.out_msg[IA+WA-1 -: IA]), 64'd1);
    step_a();
    bus_a.in_val = '0;
    step_a();
    step_a();

    // Wrap: park the pointer at 3, then offer requesters 0 and 3.
    bus_a.in_val = 4'b0100;
    step_a();
    check("wrap_ptr3", 64'(ptr_a), 64'd3);
    bus_a.in_val = 4'b1001;
    step_a();
    check("wrap_first_id", 64'(bus_a.out_msg[IA+WA-1 -: IA]), 64'd3);
    check("wrap_ptr0", 64'(ptr_a), 64'd0);
    step_a();
    check("wrap_second_id", 64'(bus_a.out_msg[IA+WA-1 -: IA]), 64'd0);
    bus_a.in_val = '0;
    step_a();

    // Asynchronous reset mid-stream: outputs clear with no clock edge.
    bus_a.in_val = '1;
    for (int s = 0; s < 3; s++) step_a();
    #2;
    reset = 1'b0;
    #1;
    check("async_out_val", 64'(bus_a.out_val), 64'd0);
    check("async_out_msg", 64'(bus_a.out_msg), 64'd0);
    check("async_grant_ptr", 64'(ptr_a), 64'd0);
    check("async_xfer_count", 64'(cnt_a), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step_a();
    check("resume_id", 64'(bus_a.out_msg[IA+WA-1 -: IA]), 64'd0);
    bus_a.in_val = '0;
    step_a();

    // Instance B: 3 requesters, random-delay sink, 30 messages.
    recv         = 0;
    wait_b       = 0;
    mb_ptr       = '0;
    bus_b.in_val = '1;
    for (int cyc = 0; cyc < 1000 && recv < 30; cyc++) begin
      bus_b.out_rdy = (wait_b == 0);
      #1;
      onehot_b = NB'(1) << mb_ptr;
      acc_b    = bus_b.in_rdy & bus_b.in_val;
      check("b_in_rdy", 64'(acc_b),
            64'((!bus_b.out_val || bus_b.out_rdy) ? onehot_b : '0));
      if (bus_b.out_val && bus_b.out_rdy) begin
        check("b_sb_nonempty", 64'(exp_qb.size() != 0), 64'd1);
        if (exp_qb.size() != 0) check("b_out_msg", 64'(bus_b.out_msg), 64'(exp_qb.pop_front()));
        recv++;
        wait_b = $urandom_range(0, 4);
      end else if (wait_b > 0) begin
        wait_b--;
      end
      bp = int'(mb_ptr);
      if (acc_b != '0) begin
        exp_qb.push_back({mb_ptr, payb[bp]});
        mb_ptr = (bp == NB - 1) ? '0 : IB'(bp + 1);
      end
      @(posedge clk);
      @(negedge clk);
      if (acc_b != '0) payb[bp] = payb[bp] + 16'd1;
    end
    bus_b.in_val  = '0;
    bus_b.out_rdy = 1'b0;
    check("b_recv30", 64'(recv), 64'd30);
    check("b_xfer30", 64'(cnt_b), 64'd30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/test_sink_rr_arbiter.md
Name:
test_sink_rr_arbiter

Overview:
- Round-robin arbiter that shares one random-delay test sink between several val/rdy message sources in a test harness.
- Picks one valid requester per cycle and registers its message, tagged with the source index, into a single-entry output buffer.
- The buffer drives the shared sink. Transfers are counted so the bench can cross-check sink completion.

Parameters:
- p_num_reqs, 4, number of requester ports (2..16).
- p_msg_nbits, 32, payload width per requester.
- p_id_nbits, $clog2(p_num_reqs) with a minimum of 1, width of the source tag.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_val  input  p_num_reqs  per-requester valid.
- in_rdy  output  p_num_reqs  per-requester ready; at most one bit high per cycle.
- in_msg  input  p_num_reqs*p_msg_nbits  requester i occupies bits [i*p_msg_nbits +: p_msg_nbits].
- out_val  output  1  buffered message valid, toward the sink.
- out_rdy  input  1  sink ready.
- out_msg  output  p_id_nbits+p_msg_nbits  {source id, payload}; id in the MSBs.
- grant_ptr  output  p_id_nbits  current round-robin priority pointer (debug).
- xfer_count  output  32  number of completed output transfers (out_val && out_rdy).

Behaviour:
- Reset (reset==0, asynchronous assert, synchronous deassert by the bench):
  - out_val=0, out_msg=0, grant_ptr=0, xfer_count=0.
  - in_rdy=0 while reset is asserted.
  - Reset mid-transfer discards any buffered message; no partial state survives.
- Buffer accept condition: can_accept = !out_val || out_rdy. A full buffer drained this cycle may be refilled in the same cycle.
- Arbitration (combinational, evaluated each cycle):
  - Search requesters starting at grant_ptr and wrapping modulo p_num_reqs.
  - The winner is the first index with in_val=1.
  - in_rdy[winner] = can_accept; all other in_rdy bits are 0.
  - in_rdy may depend on in_val (by arbitration design).
  - out_val and out_msg are driven only from registers, with no combinational path from the in_* ports.
- On accept (in_val[w] && in_rdy[w]):
  - out_msg <= {w, in_msg[w]}; out_val <= 1.
  - grant_ptr <= (w+1) mod p_num_reqs.
  - When p_num_reqs is not a power of 2, wrap explicitly from p_num_reqs-1 to 0.
- grant_ptr is unchanged in any cycle with no accept.
- Latency:
  - An accepted message appears on out_val/out_msg the next cycle.
  - Throughput is 1 message/cycle while out_rdy stays high.
- Output fire without a new accept: out_val <= 0 next cycle; out_msg holds its old value.
- out_val=1 && out_rdy=0: out_msg is stable and all in_rdy=0 (backpressure).
- xfer_count increments by 1 on each output fire and saturates at 32'hFFFF_FFFF (no wrap).
- Fairness: with all requesters continuously valid and out_rdy=1, grants rotate 0,1,...,N-1,0,...
- Starvation bound: a continuously valid requester is granted within p_num_reqs accepts.
- Messages from a single requester leave in order; there is no reordering within a source.

Test Plan:
- Reset, then hold all in_val=1 (payloads 0xA0+i) with out_rdy=1 -> out_msg ids 0,1,2,3,0,... one per cycle from cycle 1 after the first accept; xfer_count=8 after 8 fires.
- Only requester 2 valid, 5 messages, out_rdy=1 -> 5 back-to-back outputs with id=2; grant_ptr=3 after each accept; in_rdy[0,1,3] stay 0.
- Buffer full with out_rdy=0 for 6 cycles, requesters 1 and 3 valid -> out_msg stable, in_rdy=0000. On out_rdy=1, the same-cycle refill takes requester 1 if grant_ptr<=1, otherwise 3.
- Requesters 0 and 3 valid, grant_ptr=3 -> 3 is granted first, grant_ptr wraps to 0, then 0 is granted.
- Assert reset while out_val=1 mid-stream -> out_val, out_msg, grant_ptr and xfer_count are 0 immediately, without waiting for a clock edge. After release the stream resumes from requester 0.
- p_num_reqs=3, all valid, drive the shared random-delay sink with max_delay=4 -> the sink receives a correct tagged sequence of 30 messages; xfer_count=30; no message is lost or duplicated.
